// File: rtl/iddmm_ctrl.sv
// iddmm_ctrl: outer-loop sequencer and accumulator RAM for iddmm_cal.
// Streams j-beats per word i, waits for the last write-back, then steps i.
module iddmm_ctrl #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] x_rd_addr,
  output logic [ADDR_W-1:0] y_rd_addr,
  output logic [ADDR_W-1:0] p_rd_addr,
  input  logic [K-1:0]      x_rd_data,
  input  logic [K-1:0]      y_rd_data,
  input  logic [K-1:0]      p_rd_data,
  input  logic [K-1:0]      p1_in,
  output logic [ADDR_W:0]   cal_j_cnt,
  output logic [K-1:0]      cal_a,
  output logic [K-1:0]      cal_x,
  output logic [K-1:0]      cal_y,
  output logic [K-1:0]      cal_p,
  output logic [K-1:0]      cal_p1,
  input  logic              cal_wr_en,
  input  logic [ADDR_W:0]   cal_wr_addr,
  input  logic [K-1:0]      cal_wr_data,
  input  logic [ADDR_W-1:0] res_rd_addr,
  output logic [K-1:0]      res_rd_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [ADDR_W:0]   LP_N   = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] LP_NM1 = ADDR_W'(N-1);

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_j;
  logic [ADDR_W-1:0] r_i;
  logic [K-1:0]      r_mem [N];
  logic              r_bv;
  logic              r_dv;
  logic [ADDR_W:0]   r_jc;
  logic [K-1:0]      r_a;
  logic [K-1:0]      r_p1;
  logic [K-1:0]      r_res;

  logic w_issue;
  logic w_rd;
  logic w_last;
  logic w_wr;

  assign w_issue = (r_state == S_ISSUE);
  assign w_rd    = w_issue && (r_j != LP_N);
  assign w_last  = cal_wr_en && (cal_wr_addr == {1'b0, LP_NM1});
  assign w_wr    = cal_wr_en && (cal_wr_addr < LP_N)
                && (r_state != S_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_i     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_j <= '0;
          if (start) r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          r_j <= r_j + 1'b1;
          if (r_j == {1'b0, LP_NM1}) begin
            r_j     <= '0;
            r_i     <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_j <= r_j + 1'b1;
          if (r_j == LP_N) begin
            r_j     <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_last) r_state <= S_HOLD;
        end
        // one idle beat lets the c-chain flush before A is re-read
        S_HOLD: begin
          if (r_i == LP_NM1) begin
            r_state <= S_FINISH;
          end else begin
            r_i     <= r_i + 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR)
      r_mem[r_j[ADDR_W-1:0]] <= '0;
    else if (w_wr)
      r_mem[cal_wr_addr[ADDR_W-1:0]] <= cal_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bv  <= 1'b0;
      r_dv  <= 1'b0;
      r_jc  <= '0;
      r_a   <= '0;
      r_p1  <= '0;
      r_res <= '0;
    end else begin
      r_bv  <= w_issue;
      r_dv  <= w_rd;
      r_jc  <= w_issue ? r_j : '0;
      r_a   <= w_rd ? r_mem[r_j[ADDR_W-1:0]] : '0;
      r_p1  <= p1_in;
      r_res <= r_mem[res_rd_addr];
    end
  end

  assign busy = (r_state == S_CLEAR) || (r_state == S_ISSUE)
             || (r_state == S_DRAIN) || (r_state == S_HOLD);
  assign done = (r_state == S_FINISH);

  assign x_rd_addr = w_rd ? r_j[ADDR_W-1:0] : '0;
  assign p_rd_addr = w_rd ? r_j[ADDR_W-1:0] : '0;
  assign y_rd_addr = w_issue ? r_i : '0;

  // external RAM data lands one cycle after the address
  assign cal_j_cnt   = r_jc;
  assign cal_x       = r_dv ? x_rd_data : '0;
  assign cal_p       = r_dv ? p_rd_data : '0;
  assign cal_y       = r_bv ? y_rd_data : '0;
  assign cal_a       = r_a;
  assign cal_p1      = r_p1;
  assign res_rd_data = r_res;

endmodule
